// File: rtl/systolic_drain.sv
// Systolic array drain: collects per-row east-end words into a double-buffered
// N x N store and replays each matrix row-major on one valid/ready stream.
// Optional build macro DRAIN_DROP_CNT_EN adds a saturating dropped-word counter.
module systolic_drain #(
    parameter int N       = 4,
    parameter int D_W_ACC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*D_W_ACC-1:0] in_data,
    input  logic [N-1:0]         in_valid,
    output logic [D_W_ACC-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 overflow
`ifdef DRAIN_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    // Stream handshake: a word transfers on every rising edge where m_valid and
    // m_ready are both high; m_data/m_last hold while m_valid is high and m_ready low.
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rd_state_t;

    logic [D_W_ACC-1:0] mem [2][N][N];
    bank_state_t        bank_state [2];
    logic [N-1:0]       done [2];
    logic [CW-1:0]      wcnt [N];
    logic [CW-1:0]      wcol [N];
    logic [N-1:0]       wbank;
    logic [N-1:0]       wr_en;
    logic [N-1:0]       drop;
    logic [1:0]         bank_hit;

    rd_state_t          rd_state, rd_next;
    logic               rptr;
    logic [CW-1:0]      rrow, rcol, nrow, ncol;
    logic               start_read, last_hs;

    // Rows arrive east-first, so the write column counts down from N-1.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wcol[i]  = LAST_IDX - wcnt[i];
            wr_en[i] = in_valid[i] && (bank_state[wbank[i]] == B_EMPTY ||
                                       bank_state[wbank[i]] == B_FILLING);
            drop[i]  = in_valid[i] && !wr_en[i];
        end
        bank_hit[0] = |(wr_en & ~wbank);
        bank_hit[1] = |(wr_en & wbank);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_en[i]) mem[wbank[i]][i][wcol[i]] <= in_data[i*D_W_ACC +: D_W_ACC];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= B_EMPTY;
                done[b]       <= '0;
            end
            for (int i = 0; i < N; i++) wcnt[i] <= '0;
            wbank    <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) begin
                    if (wcnt[i] == LAST_IDX) begin
                        wcnt[i]           <= '0;
                        wbank[i]          <= ~wbank[i];
                        done[wbank[i]][i] <= 1'b1;
                    end else begin
                        wcnt[i] <= wcnt[i] + 1'b1;
                    end
                end
            end
            // Write side only moves EMPTY/FILLING, read side only FULL/READING.
            for (int b = 0; b < 2; b++) begin
                case (bank_state[b])
                    B_EMPTY:   if (bank_hit[b]) bank_state[b] <= B_FILLING;
                    B_FILLING: if (&done[b]) bank_state[b] <= B_FULL;
                    B_FULL:    if (start_read && rptr == 1'(b)) bank_state[b] <= B_READING;
                    B_READING: if (last_hs && rptr == 1'(b)) begin
                        bank_state[b] <= B_EMPTY;
                        done[b]       <= '0;
                    end
                    default:   bank_state[b] <= B_EMPTY;
                endcase
            end
            overflow <= overflow | (|drop);
        end
    end

`ifdef DRAIN_DROP_CNT_EN
    logic [16:0] drop_sum;
    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < N; i++) drop_sum = drop_sum + 17'(drop[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

    always_comb begin
        start_read = (rd_state == R_IDLE) && (bank_state[rptr] == B_FULL);
        last_hs    = (rd_state == R_SEND) && m_ready && (rrow == LAST_IDX) && (rcol == LAST_IDX);
        ncol       = (rcol == LAST_IDX) ? '0 : rcol + 1'b1;
        nrow       = (rcol == LAST_IDX) ? rrow + 1'b1 : rrow;
        rd_next    = rd_state;
        case (rd_state)
            R_IDLE:  if (start_read) rd_next = R_LOAD;
            R_LOAD:  rd_next = R_SEND;
            R_SEND:  if (last_hs) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= R_IDLE;
        else        rd_state <= rd_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            rptr    <= 1'b0;
            rrow    <= '0;
            rcol    <= '0;
        end else begin
            case (rd_state)
                R_LOAD: begin
                    m_valid <= 1'b1;
                    m_last  <= 1'b0;
                    m_data  <= mem[rptr][0][0];
                    rrow    <= '0;
                    rcol    <= '0;
                end
                R_SEND: if (m_ready) begin
                    if (last_hs) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        rptr    <= ~rptr;
                    end else begin
                        rrow    <= nrow;
                        rcol    <= ncol;
                        m_data  <= mem[rptr][nrow][ncol];
                        m_last  <= (nrow == LAST_IDX) && (ncol == LAST_IDX);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
